alu_arbiter: RTL and testbench

Two-port arbiter that shares the single 32-bit combinational ALU between two requesters (e.g. the main datapath and an address/branch helper). It accepts one operation at a time through a valid/ready handshake, drives the ALU ports from registered operands, captures `result`/`zero`, and returns them to the winning requester through a response handshake. Arbitration is round-robin. At most one operation is in flight.

---
 rtl/alu_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 32-bit combinational ALU between two requesters.
// Latency: accept in cycle c, ALU driven in c+1, response valid in c+2; one op in flight, issue every >=3 cycles.
// Backpressure: requests see ready=0 outside IDLE; a response is held stable until its rspN_ready.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   reqN_valid/ready/opA/opB/op   request handshake and operation from requester N (N = 0, 1)
//   alu_opA/opB/op, alu_result/zero  connection to the shared combinational ALU
//   rspN_valid/ready/result/zero/err response handshake back to requester N
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_opA,
  input  logic [31:0] req0_opB,
  input  logic [3:0]  req0_op,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_opA,
  input  logic [31:0] req1_opB,
  input  logic [3:0]  req1_op,

  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_err,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q,  last_d;
  logic [3:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [31:0] res_q,   res_d;
  logic        zero_q,  zero_d;
  logic        err_q,   err_d;

  logic        gnt_vld;
  logic        gnt_id;
  logic        accept;
  logic        op_legal;
  logic        own_rsp_rdy;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

  // Round-robin grant: a lone requester always wins; on a tie the one not
  // served last wins. last_q resets to 1 so requester 0 takes the first tie.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = req1_valid;
    end
  end

  // Readies are held low while reset is asserted so nothing is accepted in
  // the same cycle the arbiter is being cleared.
  assign req0_ready = (state_q == IDLE) && !reset && gnt_vld && !gnt_id;
  assign req1_ready = (state_q == IDLE) && !reset && gnt_vld &&  gnt_id;
  assign accept     = req0_ready | req1_ready;

  assign op_legal    = is_legal_op(op_q);
  assign own_rsp_rdy = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state and ALU drive.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    alu_opA = 32'd0;
    alu_opB = 32'd0;
    alu_op  = 4'd0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt_id;
          op_d    = gnt_id ? req1_op  : req0_op;
          a_d     = gnt_id ? req1_opA : req0_opA;
          b_d     = gnt_id ? req1_opB : req0_opB;
          state_d = EXEC;
        end
      end

      EXEC: begin
        alu_opA = a_q;
        alu_opB = b_q;
        // An illegal code never reaches the ALU; it sees a harmless AND and
        // its output is discarded in favour of the error response.
        alu_op  = op_legal ? op_q : OP_AND;
        if (op_legal) begin
          res_d  = alu_result;
          zero_d = alu_zero;
          err_d  = 1'b0;
        end else begin
          res_d  = 32'd0;
          zero_d = 1'b1;
          err_d  = 1'b1;
        end
        state_d = RESP;
      end

      RESP: begin
        if (own_rsp_rdy) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Response steering: only the owner's port carries data, the other is 0.
  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) &&  owner_q;
  assign rsp0_result = rsp0_valid ? res_q  : 32'd0;
  assign rsp0_zero   = rsp0_valid ? zero_q : 1'b0;
  assign rsp0_err    = rsp0_valid ? err_q  : 1'b0;
  assign rsp1_result = rsp1_valid ? res_q  : 32'd0;
  assign rsp1_zero   = rsp1_valid ? zero_q : 1'b0;
  assign rsp1_err    = rsp1_valid ? err_q  : 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small combinational ALU model.
// Latency: checks accept/EXEC/RESP at c, c+1, c+2 of each operation.
// Backpressure: exercises held responses and requests waiting outside IDLE.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_opA, req0_opB;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_opA, req1_opB;
  logic [3:0]  req1_op;
  logic [31:0] alu_opA, alu_opB;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_result;
  logic        rsp1_zero, rsp1_err;

  int n_checks;
  int n_errors;

  alu_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opA    (req0_opA),
    .req0_opB    (req0_opB),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opA    (req1_opA),
    .req1_opB    (req1_opB),
    .req1_op     (req1_op),
    .alu_opA     (alu_opA),
    .alu_opB     (alu_opB),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_err    (rsp1_err)
  );

  // Reference ALU attached to the arbiter's ALU ports.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_opA & alu_opB;
      4'b0001: alu_result = alu_opA | alu_opB;
      4'b0010: alu_result = alu_opA + alu_opB;
      4'b0110: alu_result = alu_opA - alu_opB;
      4'b0111: alu_result = (alu_opA < alu_opB) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_opA | alu_opB);
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    req0_valid = 1'b0; req0_opA = 32'd0; req0_opB = 32'd0; req0_op = 4'd0;
    req1_valid = 1'b0; req1_opA = 32'd0; req1_opB = 32'd0; req1_op = 4'd0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset state; a request during reset must not be granted.
    tick();
    req0_valid = 1'b1; req0_op = 4'b0010; req0_opA = 32'd5; req0_opB = 32'd7;
    tick();
    sample();
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_alu_op",     32'(alu_op),     32'd0);
    chk("rst_alu_opA",    alu_opA,         32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_res",   rsp0_result,     32'd0);

    // Single ADD 5+7 from requester 0.
    tick();
    reset = 1'b0;
    sample();
    chk("add_req0_ready", 32'(req0_ready), 32'd1);
    chk("add_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    sample();
    chk("add_exec_op",    32'(alu_op),     32'h2);
    chk("add_exec_A",     alu_opA,         32'd5);
    chk("add_exec_B",     alu_opB,         32'd7);
    chk("add_exec_rspv",  32'(rsp0_valid), 32'd0);
    tick();
    sample();
    chk("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("add_rsp0_res",   rsp0_result,     32'd12);
    chk("add_rsp0_zero",  32'(rsp0_zero),  32'd0);
    chk("add_rsp0_err",   32'(rsp0_err),   32'd0);
    chk("add_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("add_resp_aluop", 32'(alu_op),     32'd0);
    tick();
    sample();
    chk("add_done_rspv",  32'(rsp0_valid), 32'd0);
    chk("add_done_aluop", 32'(alu_op),     32'd0);

    // Fresh reset so the first tie goes to requester 0, then continuous contention.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0110; req0_opA = 32'd9;     req0_opB = 32'd9;
    req1_valid = 1'b1; req1_op = 4'b0001; req1_opA = 32'h0000_00F0; req1_opB = 32'h0000_000F;
    for (int k = 0; k < 4; k++) begin
      logic sel;
      sel = 1'(k % 2);
      sample();
      chk("rr_req0_ready", 32'(req0_ready), sel ? 32'd0 : 32'd1);
      chk("rr_req1_ready", 32'(req1_ready), sel ? 32'd1 : 32'd0);
      tick();
      sample();
      chk("rr_exec_op",    32'(alu_op), sel ? 32'h1 : 32'h6);
      chk("rr_exec_rdy",   32'(req0_ready | req1_ready), 32'd0);
      tick();
      sample();
      chk("rr_rsp0_valid", 32'(rsp0_valid), sel ? 32'd0 : 32'd1);
      chk("rr_rsp1_valid", 32'(rsp1_valid), sel ? 32'd1 : 32'd0);
      chk("rr_rsp_res",    sel ? rsp1_result : rsp0_result, sel ? 32'h0000_00FF : 32'd0);
      chk("rr_rsp_zero",   32'(sel ? rsp1_zero : rsp0_zero), sel ? 32'd0 : 32'd1);
      chk("rr_resp_rdy",   32'(req0_ready | req1_ready), 32'd0);
      tick();
    end

    // Unsigned SLT from requester 1 with its response held off for 5 cycles.
    req0_valid = 1'b0;
    req0_op = 4'b0101; req0_opA = 32'd1; req0_opB = 32'd2;
    req1_op = 4'b0111; req1_opA = 32'd3; req1_opB = 32'hFFFF_FFFF;
    rsp1_ready = 1'b0;
    sample();
    chk("slt_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    sample();
    chk("slt_exec_op",    32'(alu_op),     32'h7);
    chk("slt_exec_r0rdy", 32'(req0_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("slt_hold_valid", 32'(rsp1_valid), 32'd1);
      chk("slt_hold_res",   rsp1_result,     32'd1);
      chk("slt_hold_r0rdy", 32'(req0_ready), 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    sample();
    chk("slt_rel_valid",  32'(rsp1_valid), 32'd1);
    chk("slt_rel_r0rdy",  32'(req0_ready), 32'd0);
    tick();

    // Illegal op 0101 from requester 0 (already waiting).
    sample();
    chk("ill_rsp1_gone",  32'(rsp1_valid), 32'd0);
    chk("ill_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    sample();
    chk("ill_exec_op",    32'(alu_op),     32'd0);
    chk("ill_exec_A",     alu_opA,         32'd1);
    chk("ill_exec_B",     alu_opB,         32'd2);
    tick();
    sample();
    chk("ill_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("ill_rsp0_err",   32'(rsp0_err),   32'd1);
    chk("ill_rsp0_res",   rsp0_result,     32'd0);
    chk("ill_rsp0_zero",  32'(rsp0_zero),  32'd1);
    tick();

    // Reset during EXEC of a requester-1 NOR abandons it and restores last=1.
    req1_valid = 1'b1; req1_op = 4'b1100; req1_opA = 32'h0F0F_0000; req1_opB = 32'h0000_F0F0;
    sample();
    chk("nor_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    reset = 1'b1;
    sample();
    chk("nor_exec_op",    32'(alu_op), 32'hC);
    tick();
    reset = 1'b0;
    sample();
    chk("nor_no_rsp1_a",  32'(rsp1_valid), 32'd0);
    chk("nor_no_alu",     32'(alu_op),     32'd0);
    tick();
    sample();
    chk("nor_no_rsp1_b",  32'(rsp1_valid), 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("tie_req0_ready", 32'(req0_ready), 32'd1);
    chk("tie_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
